fifo_rd_stream: RTL and testbench

- Read-side controller for the synchronous FIFO. It drives the FIFO read port (r_en / out_data / empty) and turns it into a valid/ready stream for downstream logic.
- Hides the FIFO's one-cycle registered read latency using an in-flight flag and a 2-entry skid buffer. Sustains one word per clock when the FIFO is non-empty and downstream is always ready.
- Sits between the FIFO's read side and the consumer, as the counterpart to the write-side producer.

---
 rtl/fifo_rd_stream.sv | 81 ++++++++
 tb/tb_fifo_rd_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the synchronous FIFO. It hides the one-cycle read latency
// behind a 2-entry skid buffer. Define FIFO_RD_CNT_EN to add the rd_count popped-word counter.
module fifo_rd_stream #(
   parameter int unsigned Width    = 16,
   parameter int unsigned CntWidth = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [Width-1:0] fifo_out_data,
   output logic             fifo_r_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [Width-1:0] m_data
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CntWidth-1:0] rd_count
`endif
);

   logic [Width-1:0] skid_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic             inflight_q;
   logic [1:0]       cnt_q;
   logic [1:0]       occ;
   logic             pop;
   logic             capture;

   assign pop     = m_valid & m_ready;
   assign occ     = cnt_q + {1'b0, inflight_q};
   assign capture = inflight_q & ~flush;
   assign m_valid = (cnt_q != 2'd0);
   assign m_data  = skid_q[rd_ptr_q];

   // A read may be issued into a full occupancy only if a slot frees up this same cycle.
   assign fifo_r_en = rst & ~fifo_empty & ~flush &
                      ((occ < 2'd2) | ((occ == 2'd2) & pop));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
      end else if (flush) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         inflight_q <= fifo_r_en;
         if (capture) begin
            skid_q[wr_ptr_q] <= fifo_out_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + {1'b0, capture} - {1'b0, pop};
      end
   end

`ifdef FIFO_RD_CNT_EN
   // Words popped while flushing are discarded and so not counted; flush leaves the count intact.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count <= '0;
      end else if (pop && !flush) begin
         rd_count <= rd_count + 1'b1;
      end
   end
`else
   logic [CntWidth-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based FIFO environment plus a reference model
// tracking words that have left the FIFO but have not yet been delivered downstream.
module tb_fifo_rd_stream;

   localparam int unsigned Width    = 16;
   localparam int unsigned CntWidth = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             fifo_empty = 1'b1;
   logic [Width-1:0] fifo_out_data = '0;
   logic             fifo_r_en;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [Width-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
   logic [CntWidth-1:0] rd_count;
`endif

   fifo_rd_stream #(
      .Width    (Width),
      .CntWidth (CntWidth)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .fifo_empty    (fifo_empty),
      .fifo_out_data (fifo_out_data),
      .fifo_r_en     (fifo_r_en),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_count      (rd_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [Width-1:0] fifo_q [$];  // words still inside the FIFO
   logic [Width-1:0] pend_q [$];  // words read out of the FIFO, not yet delivered
   logic [Width-1:0] del_q  [$];  // words delivered downstream in this test
   bit               infl_m;
   int unsigned      pops_m;
   int               reads;
   int               cyc;
   int               first_ren_cyc;
   int               first_val_cyc;
   int               first_pop_cyc;
   int               last_pop_cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      del_q.delete();
      reads         = 0;
      cyc           = 0;
      first_ren_cyc = -1;
      first_val_cyc = -1;
      first_pop_cyc = -1;
      last_pop_cyc  = -1;
   endtask

   task automatic clear_model();
      fifo_q.delete();
      pend_q.delete();
      infl_m        = 1'b0;
      pops_m        = 0;
      fifo_out_data = '0;
      fifo_empty    = 1'b1;
      clear_stats();
   endtask

   task automatic load(input int n);
      for (int i = 1; i <= n; i++) fifo_q.push_back(Width'(i));
   endtask

   // Entered and left at posedge+1: applies inputs, checks outputs, advances one clock.
   task automatic cycle(input bit rdy, input bit fl, input bit push_rand);
      int cap;
      bit pop_e;
      bit ren_s;
      bit pop_s;
      m_ready    = rdy;
      flush      = fl;
      fifo_empty = (fifo_q.size() == 0);
      #1;
      cap   = pend_q.size() - int'(infl_m);
      pop_e = (cap > 0) && rdy;
      check_eq("m_valid", m_valid, (cap > 0));
      if (cap > 0) check_eq("m_data", m_data, pend_q[0]);
      check_eq("fifo_r_en", fifo_r_en,
               !fifo_empty && !fl && (pend_q.size() < 2 || (pend_q.size() == 2 && pop_e)));
      check_eq("occ_le2", (pend_q.size() <= 2), 1);
`ifdef FIFO_RD_CNT_EN
      check_eq("rd_count", rd_count, pops_m % (1 << CntWidth));
`endif
      ren_s = fifo_r_en;
      pop_s = m_valid & m_ready;
      if (ren_s && first_ren_cyc < 0) first_ren_cyc = cyc;
      if (m_valid && first_val_cyc < 0) first_val_cyc = cyc;
      @(posedge clk);
      #1;
      fifo_out_data = Width'($urandom);
      infl_m        = 1'b0;
      if (fl) begin
         pend_q.delete();
      end else begin
         if (pop_s && pend_q.size() > 0) begin
            del_q.push_back(pend_q.pop_front());
            pops_m++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         if (ren_s && fifo_q.size() > 0) begin
            fifo_out_data = fifo_q.pop_front();
            pend_q.push_back(fifo_out_data);
            infl_m = 1'b1;
            reads++;
         end
      end
      if (push_rand && $urandom_range(0, 1) == 1) fifo_q.push_back(Width'($urandom));
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_model();
      flush   = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_r_en", fifo_r_en, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_seq(input string tag, input int first, input int n);
      check_eq({tag, "_count"}, del_q.size(), n);
      for (int i = 0; i < n && i < del_q.size(); i++) check_eq(tag, del_q[i], first + i);
   endtask

   initial begin
      // Preloaded FIFO, always-ready consumer
      do_reset();
      load(8);
      repeat (14) cycle(1'b1, 1'b0, 1'b0);
      check_seq("stream8", 1, 8);
      check_eq("ren_first_cycle", first_ren_cyc, 0);
      check_eq("valid_latency", first_val_cyc - first_ren_cyc, 2);
      check_eq("no_bubbles", last_pop_cyc - first_pop_cyc, 7);
      check_eq("drained_valid", m_valid, 0);

      // Backpressure: only two reads may be outstanding
      do_reset();
      load(8);
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      check_eq("bp_reads", reads, 2);
      check_eq("bp_valid", m_valid, 1);
      check_eq("bp_data", m_data, 1);
      repeat (14) cycle(1'b1, 1'b0, 1'b0);
      check_seq("bp_stream", 1, 8);

      // Alternating ready
      do_reset();
      load(11);
      for (int i = 0; i < 40; i++) cycle(i[0], 1'b0, 1'b0);
      check_seq("toggle", 1, 11);

      // Flush with one word buffered and one in flight; word 1 was delivered beforehand
      do_reset();
      load(6);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("pre_flush_reads", reads, 3);
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("flush_valid", m_valid, 0);
      del_q.delete();
      repeat (10) cycle(1'b1, 1'b0, 1'b0);
      check_seq("post_flush", 4, 3);

      // Asynchronous reset in the middle of a stream
      do_reset();
      load(8);
      repeat (4) cycle(1'b1, 1'b0, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      check_eq("arst_valid", m_valid, 0);
      check_eq("arst_r_en", fifo_r_en, 0);
      check_eq("arst_data", m_data, 0);
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      load(3);
      repeat (8) cycle(1'b1, 1'b0, 1'b0);
      check_seq("after_arst", 1, 3);

      // Random traffic with occasional flushes
      do_reset();
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
